rf_write_arbiter: RTL



---
 rtl/rf_write_arbiter_pkg.sv | 16 +
 rtl/decoder_5x32.sv | 20 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/rf_write_arbiter.sv | 88 ++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults and requester identifiers for the register-file write arbiter.
// The top module, the arbiter and the bench all use these values.
package rf_write_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREG   = 32;
    localparam int DEF_CNT_W  = 16;

    // A requester ID is also that requester's bit position in the req/gnt vectors.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/decoder_5x32.sv
// Binary-to-one-hot decoder that drives the per-register load enables.
// When en is low, every output is low.
module decoder_5x32 #(
    parameter int AW = 5,
    parameter int N  = 32
) (
    input  logic [AW-1:0] a,
    input  logic          en,
    output logic [N-1:0]  y
);

    // NOTE: give every always_comb output a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational.
// The last_gnt pointer gives priority to whichever requester was not served most recently.
module rr_arb2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e last_gnt;

    always_comb begin
        gnt = '0;
        if (!reset && !hold) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_gnt == REQ_B) ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // A grant is only ever issued to a requester that is asserting REQ.
    // Any grant is therefore a transfer, and the pointer moves to that requester.
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= REQ_B;
        end else if (|gnt) begin
            last_gnt <= gnt[REQ_B] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (B) writeback paths.
// The winning write is registered and presented as one-hot LOAD enables plus shared data one cycle later.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = DEF_NREG,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              HOLD,
    input  logic              A_REQ,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_GNT,
    input  logic              B_REQ,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_GNT,
    output logic [NREG-1:0]   LOAD_OUT,
    output logic [DATA_W-1:0] D_OUT,
    output logic [CNT_W-1:0]  CONTEND_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              transfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREG-1:0]   load_dec;
    logic              contend;

    assign req = {B_REQ, A_REQ};

    rr_arb2 u_arb (
        .clk   (CLK),
        .reset (RESET),
        .hold  (HOLD),
        .req   (req),
        .gnt   (gnt)
    );

    assign A_GNT    = gnt[REQ_A];
    assign B_GNT    = gnt[REQ_B];
    assign transfer = |gnt;
    assign win_addr = gnt[REQ_B] ? B_ADDR : A_ADDR;
    assign win_data = gnt[REQ_B] ? B_DATA : A_DATA;

    // Register 0 is hard-wired to zero. A write to it still completes the handshake, but no load enable is asserted.
    decoder_5x32 #(
        .AW (ADDR_W),
        .N  (NREG)
    ) u_dec (
        .a  (win_addr),
        .en (transfer && (win_addr != '0)),
        .y  (load_dec)
    );

    // The load enables last exactly one cycle. The data output holds its value between writes.
    // Reset clears any write that was registered but not yet committed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LOAD_OUT <= '0;
            D_OUT    <= '0;
        end else begin
            LOAD_OUT <= load_dec;
            if (transfer) begin
                D_OUT <= win_data;
            end
        end
    end

    // Each un-held cycle in which both requesters ask denies one of them.
    assign contend = A_REQ & B_REQ & ~HOLD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            CONTEND_CNT <= '0;
        end else if (contend && (CONTEND_CNT != CNT_MAX)) begin
            CONTEND_CNT <= CONTEND_CNT + 1'b1;
        end
    end

endmodule
